// File: rtl/gate_test_pkg.sv
// Shared types and constants for the 2-input gate exerciser family.
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2
  } state_t;

  // Expected y for each vector, indexed by {a,b}
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  localparam logic [1:0] VEC_LAST = 2'd3;

endpackage

// File: rtl/gate_exerciser_settle_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Load takes priority; otherwise count down to zero and stick there
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (en && cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/gate_exerciser.sv
// Sweeps a 2-input gate through 00,01,10,11, holds each vector for
// SETTLE_CYCLES+1 cycles, and scores y against a truth table latched at start.
module gate_exerciser
  import gate_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] exp_table,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic       fail_valid,
  output logic [1:0] fail_vec
);

  localparam int TW = 8;

  state_t     state;
  logic [1:0] vec;
  logic [3:0] exp_q;

  logic       tmr_load;
  logic       tmr_expired;
  logic       mismatch;
  logic [2:0] err_next;

  // Timer is reloaded on every entry into SETTLE; expiry after SETTLE_CYCLES
  // cycles in SETTLE means it starts at SETTLE_CYCLES-1.
  assign tmr_load = ((state == IDLE) && start) ||
                    ((state == CHECK) && (vec != VEC_LAST));

  settle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (TW'(SETTLE_CYCLES - 1)),
    .en       (state == SETTLE),
    .expired  (tmr_expired)
  );

  // Compare is combinational off y; only consumed on the edge leaving CHECK
  assign mismatch = (y != exp_q[vec]);
  assign err_next = err_count + {2'b00, mismatch};

  // Sweep sequencer with registered stimulus and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= 2'd0;
      exp_q      <= 4'd0;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 3'd0;
      fail_valid <= 1'b0;
      fail_vec   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            exp_q      <= exp_table;
            vec        <= 2'd0;
            {a, b}     <= 2'b00;
            err_count  <= 3'd0;
            fail_valid <= 1'b0;
            fail_vec   <= 2'd0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (tmr_expired) state <= CHECK;
        end
        CHECK: begin
          err_count <= err_next;
          // Only the first failing vector is kept
          if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_vec   <= vec;
          end
          if (vec != VEC_LAST) begin
            vec    <= vec + 2'd1;
            {a, b} <= vec + 2'd1;
            state  <= SETTLE;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 3'd0);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gate_exerciser.md
Name: gate_exerciser

Overview:
- Sequential stimulus-and-check stage that sits upstream of, and around, a 2-input gate model such as the NAND gate.
- Drives the gate's a/b inputs through all four combinations, holds each for a programmable settle time, then samples y.
- Compares y against a 4-entry expected truth table latched at start, and reports pass/fail, error count and first failing vector.
- Lets any 2-input gate model be exercised in hardware, not only from an initial-block bench.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before y is sampled; legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled launch request; acted on only in IDLE.
- exp_table  input  4  expected y for each vector, indexed by {a,b}. NAND = 4'b0111, AND = 4'b1000.
- y  input  1  output of the gate under test (combinational).
- a  output  1  gate input a (registered).
- b  output  1  gate input b (registered).
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  3  number of mismatching vectors, 0..4.
- fail_valid  output  1  at least one mismatch recorded this sweep.
- fail_vec  output  2  {a,b} of the first mismatch; 0 when fail_valid=0.

Behaviour:
- Reset, asynchronous and immediate:
  - a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0.
  - state=IDLE, internal vector and settle counter cleared.
- States: IDLE, SETTLE, CHECK.
- IDLE, start=1 at an edge:
  - latch exp_table into exp_q; vec<=0; {a,b}<=2'b00.
  - clear err_count, fail_valid, fail_vec, done, pass; busy<=1; settle_cnt<=0; go to SETTLE.
- SETTLE:
  - settle_cnt increments each cycle.
  - after SETTLE_CYCLES cycles in SETTLE, go to CHECK.
- CHECK, exactly one cycle; y sampled at the edge leaving CHECK:
  - If y != exp_q[vec]: err_count+1. If fail_valid=0, set fail_valid=1 and fail_vec=vec; later mismatches do not overwrite it.
  - If vec != 3: vec+1, {a,b}<=vec+1, settle_cnt<=0, go to SETTLE.
  - If vec == 3: go to IDLE with busy<=0, done<=1, pass<=(final err_count==0). The final count includes this CHECK's mismatch.
- Latency: start accepted at edge E0 -> done=1 after edge E0 + 4*(SETTLE_CYCLES+1).
- Each vector drives a/b for exactly SETTLE_CYCLES+1 cycles.
- Vector order is fixed: 00, 01, 10, 11. {a,b} never changes outside the SETTLE entry points.
- start while busy: ignored, with no effect on sequence or results.
- start held high continuously: a new sweep launches the cycle after done rises. done is therefore high for 1 cycle per sweep.
- exp_table changes while busy are ignored; only the value latched at start is used.
- After done, a/b hold 2'b11 until the next start or reset.
- err_count cannot exceed 4; no wrap is possible.
- Reset mid-sweep aborts immediately. No partial results are retained. The next start performs a complete fresh sweep.
- y is not synchronised internally; the gate under test must be combinational from a/b within the clock domain.

Decomposition:
- Package gate_test_pkg holds:
  - state enum (IDLE, SETTLE, CHECK);
  - truth-table constants TT_AND=4'b1000, TT_NAND=4'b0111, TT_OR=4'b1110, TT_NOR=4'b0001, TT_XOR=4'b0110, TT_XNOR=4'b1001;
  - VEC_LAST=2'd3.
- One natural sub-module: settle_timer.
  - Parameterised down-counter with load/expire, reused by future exercisers.
  - The FSM, compare and result registers stay in gate_exerciser.

Test Plan:
1. NAND gate model on y, exp_table=TT_NAND, SETTLE_CYCLES=2, start pulse:
   - a/b sequence 00, 01, 10, 11, each held 3 cycles;
   - done at E0+12; pass=1, err_count=0, fail_valid=0.
2. AND gate model on y, exp_table=TT_NAND -> all four vectors mismatch: err_count=4, pass=0, fail_valid=1, fail_vec=2'b00.
3. y tied to 1, exp_table=TT_NAND -> err_count=1, fail_vec=2'b11, pass=0.
4. start held high for 30 cycles with a correct NAND on y:
   - second sweep launches the cycle after the first done;
   - done high for exactly 1 cycle per sweep; start pulses while busy have no effect.
5. rst asserted asynchronously mid-cycle during vector 10 SETTLE:
   - all outputs go to 0 immediately, without waiting for an edge;
   - after release, a start pulse gives a full clean sweep with pass=1.
6. exp_table switched from TT_NAND to TT_AND during vector 01, correct NAND on y -> pass=1, err_count=0 (latched table used).
